uart_rx_packer: RTL and testbench
=================================

UART_RX_PACKER -- requirements
Module: uart_rx_packer

Interface
REQ-001 The module SHALL provide parameter CLOCKS_PER_PULSE, default 4, giving clocks per UART bit period (even, >=4).
REQ-002 The module SHALL provide parameter BITS_PER_WORD, default 8, giving data bits per UART character (5..16).
REQ-003 The module SHALL provide parameter N_WORDS, default 4, giving characters packed per output frame (>=1).
REQ-004 The module SHALL provide parameter TIMEOUT_PULSES, default 32, giving the idle bit periods after which a partial frame is discarded (0 disables timeout).
REQ-005 The module SHALL use one clock and a synchronous, active-high reset.
REQ-006 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 Port rx, input, 1 bit: asynchronous UART serial line, idle high.
REQ-009 Port m_data, output, N_WORDS*BITS_PER_WORD bits: packed frame, with word i in bits [i*BITS_PER_WORD +: BITS_PER_WORD].
REQ-010 Port m_valid, output, 1 bit: m_data holds a complete frame.
REQ-011 Port m_ready, input, 1 bit: the consumer accepts the frame when m_valid and m_ready are both high on a clk edge.
REQ-012 Port err_frame, output, 1 bit: one-cycle pulse on a stop-bit error.
REQ-013 Port err_overflow, output, 1 bit: sticky flag set when a completed frame is dropped.

Function
REQ-014 rx SHALL pass through a 2-flop synchronizer, and all detection SHALL use the synchronized value.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY (macro only) and STOP.
- IDLE to START on a synchronized falling edge.
REQ-016 START SHALL wait CLOCKS_PER_PULSE/2 clocks and sample rx.
- Low: go to DATA.
- High: treat as a glitch; return to IDLE with no error and word state unchanged.
REQ-017 DATA SHALL sample every CLOCKS_PER_PULSE clocks, BITS_PER_WORD samples, LSB first.
REQ-018 STOP SHALL sample once, CLOCKS_PER_PULSE after the last data/parity sample.
- High: the word is accepted.
- Low: the word is discarded, err_frame pulses for 1 cycle, and the FSM waits in IDLE for rx high before rearming.
REQ-019 An accepted word SHALL be written to slot word_idx, and word_idx SHALL increment.
- On reaching N_WORDS, the frame is complete and word_idx wraps to 0.
REQ-020 m_valid SHALL rise on the clock after the final stop-bit sample and hold, with m_data stable, until handshake.
REQ-021 On handshake, m_valid SHALL fall on the next clock unless a new frame completes on that same clock, in which case m_valid stays high with the new data.
REQ-022 If a frame completes while m_valid=1 and m_ready=0, that frame SHALL be dropped, err_overflow SHALL be set, and the held frame SHALL be unchanged.
REQ-023 Assembly SHALL continue into a separate shadow buffer while m_valid is high, so reception never stalls.
REQ-024 If TIMEOUT_PULSES>0, word_idx>0, and the FSM idles for TIMEOUT_PULSES*CLOCKS_PER_PULSE clocks, word_idx SHALL reset to 0 and the partial words SHALL be discarded silently.
REQ-025 err_overflow SHALL clear only on rst.

Reset
REQ-026 While rst=1 the module SHALL force the following state:
- FSM in IDLE, all counters and word_idx at 0.
- Synchronizer flops at 1.
- m_valid=0, m_data=0, err_frame=0, err_overflow=0.
REQ-027 Reset asserted mid-character or mid-frame SHALL discard all partial data; after release, the first falling edge on rx starts a new word 0.

Configuration
REQ-028 When macro UART_RX_PARITY_EN is defined, one even-parity bit SHALL follow the data bits (state PARITY).
- A mismatch discards the word and pulses err_frame.
- The stop bit is still checked.
REQ-029 When UART_RX_PARITY_EN is undefined, no parity bit SHALL be expected, the PARITY state SHALL be absent, and the character SHALL be 1+BITS_PER_WORD+1 bits.

Verification
REQ-030 Defaults; send 0x0A,0x0B,0x0C,0x0D with random 1-20 clk gaps and m_ready=1 -> one m_valid pulse with m_data=0x0D0C0B0A.
REQ-031 m_ready=0; send two full frames 0x04030201 then 0x08070605 -> m_data holds 0x04030201 and err_overflow=1; raise m_ready -> handshake; m_valid falls.
REQ-032 Send 0x55 with stop bit driven 0 -> err_frame pulses once, no word is stored; next 4 good bytes 0x11..0x44 -> m_data=0x44332211.
REQ-033 Send 2 bytes, idle 40 bit periods, then 4 bytes 0xA1..0xA4 -> m_data=0xA4A3A2A1, and the first 2 bytes never appear.
REQ-034 Apply a 1-clk low glitch on rx in IDLE -> no word is stored and no error is flagged.
- rst pulsed mid-byte -> the next clean frame 0xDEADBEEF is received exactly.
REQ-035 With UART_RX_PARITY_EN defined: byte 0x07 with parity 1 -> accepted; byte 0x07 with parity 0 -> err_frame pulses and the word is dropped.

Source files
------------

// File: rtl/uart_rx_packer.sv
// UART receiver that packs N_WORDS characters into one wide output frame with a valid/ready handshake.
// Define UART_RX_PARITY_EN to expect one even-parity bit between the data bits and the stop bit.
module uart_rx_packer #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int N_WORDS          = 4,
    parameter int TIMEOUT_PULSES   = 32
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rx,
    output logic [N_WORDS*BITS_PER_WORD-1:0]   m_data,
    output logic                               m_valid,
    input  logic                               m_ready,
    output logic                               err_frame,
    output logic                               err_overflow
);
    localparam int FW      = N_WORDS * BITS_PER_WORD;
    localparam int CNT_W   = $clog2(CLOCKS_PER_PULSE);
    localparam int BIT_W   = $clog2(BITS_PER_WORD);
    localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int TO_CLKS = TIMEOUT_PULSES * CLOCKS_PER_PULSE;
    localparam int TO_W    = (TO_CLKS > 1) ? $clog2(TO_CLKS) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_PULSE - 1);
    localparam logic [BIT_W-1:0] BIT_ZERO  = {BIT_W{1'b0}};
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(BITS_PER_WORD - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_WORDS - 1);
    localparam logic [TO_W-1:0]  TO_ZERO   = {TO_W{1'b0}};
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'((TO_CLKS > 0) ? TO_CLKS - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t                   r_state;
    logic                     r_rx_meta;
    logic                     r_rx_sync;
    logic                     r_rx_prev;
    logic                     r_wait_high;
    logic [CNT_W-1:0]         r_clk_cnt;
    logic [BIT_W-1:0]         r_bit_cnt;
    logic [TO_W-1:0]          r_idle_cnt;
    logic [IDX_W-1:0]         r_word_idx;
    logic [BITS_PER_WORD-1:0] r_shift;
    logic [FW-1:0]            r_words;
    logic [FW-1:0]            r_m_data;
    logic                     r_m_valid;
    logic                     r_err_frame;
    logic                     r_err_overflow;
    logic [FW-1:0]            w_frame;
    logic                     w_fall;
    logic                     w_par_bad;

`ifdef UART_RX_PARITY_EN
    logic r_par_err;

    function automatic logic even_parity(input logic [BITS_PER_WORD-1:0] d);
        return ^d;
    endfunction

    assign w_par_bad = r_par_err;
`else
    assign w_par_bad = 1'b0;
`endif

    assign w_fall       = r_rx_prev & ~r_rx_sync;
    assign m_data       = r_m_data;
    assign m_valid      = r_m_valid;
    assign err_frame    = r_err_frame;
    assign err_overflow = r_err_overflow;

    // Shadow frame: assembly buffer with the slot at word_idx replaced by the word just received
    for (genvar g = 0; g < N_WORDS; g++) begin : g_slot
        assign w_frame[g*BITS_PER_WORD +: BITS_PER_WORD] =
            (r_word_idx == IDX_W'(g)) ? r_shift : r_words[g*BITS_PER_WORD +: BITS_PER_WORD];
    end

    // Two-flop synchronizer on rx plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // Receive FSM, word packing, output handshake and error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_wait_high    <= 1'b0;
            r_clk_cnt      <= CNT_ZERO;
            r_bit_cnt      <= BIT_ZERO;
            r_idle_cnt     <= TO_ZERO;
            r_word_idx     <= IDX_ZERO;
            r_shift        <= {BITS_PER_WORD{1'b0}};
            r_words        <= {FW{1'b0}};
            r_m_data       <= {FW{1'b0}};
            r_m_valid      <= 1'b0;
            r_err_frame    <= 1'b0;
            r_err_overflow <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_err      <= 1'b0;
`endif
        end else begin
            r_err_frame <= 1'b0;
            r_idle_cnt  <= TO_ZERO;
            if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    r_clk_cnt <= CNT_ZERO;
                    r_bit_cnt <= BIT_ZERO;
                    if (r_wait_high) begin
                        r_wait_high <= ~r_rx_sync;
                    end else if (w_fall) begin
                        r_state <= S_START;
                    end
                    // A partial frame left idle too long is silently abandoned
                    if ((TIMEOUT_PULSES > 0) && (r_word_idx != IDX_ZERO)) begin
                        if (r_idle_cnt == TO_LAST) begin
                            r_word_idx <= IDX_ZERO;
                        end else begin
                            r_idle_cnt <= r_idle_cnt + 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (r_clk_cnt == HALF_LAST) begin
                        r_clk_cnt <= CNT_ZERO;
                        r_state   <= r_rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_clk_cnt == FULL_LAST) begin
                        r_clk_cnt <= CNT_ZERO;
                        r_shift   <= {r_rx_sync, r_shift[BITS_PER_WORD-1:1]};
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= BIT_ZERO;
`ifdef UART_RX_PARITY_EN
                            r_state   <= S_PARITY;
`else
                            r_state   <= S_STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_clk_cnt == FULL_LAST) begin
                        r_clk_cnt <= CNT_ZERO;
                        r_par_err <= (r_rx_sync != even_parity(r_shift));
                        r_state   <= S_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_clk_cnt == FULL_LAST) begin
                        r_clk_cnt <= CNT_ZERO;
                        r_state   <= S_IDLE;
                        if (!r_rx_sync || w_par_bad) begin
                            r_err_frame <= 1'b1;
                            r_wait_high <= ~r_rx_sync;
                        end else begin
                            r_words <= w_frame;
                            if (r_word_idx == IDX_LAST) begin
                                r_word_idx <= IDX_ZERO;
                                // Held frame is never overwritten; a frame arriving behind it is lost
                                if (!r_m_valid || m_ready) begin
                                    r_m_data  <= w_frame;
                                    r_m_valid <= 1'b1;
                                end else begin
                                    r_err_overflow <= 1'b1;
                                end
                            end else begin
                                r_word_idx <= r_word_idx + 1'b1;
                            end
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed bench for uart_rx_packer: a character-level model predicts frames, errors and overflow.
`timescale 1ns/1ps
module tb_uart_rx_packer;
    localparam int CPP     = 4;
    localparam int W       = 8;
    localparam int N       = 4;
    localparam int TOP     = 32;
    localparam int FW      = N * W;
    localparam int TO_CLKS = TOP * CPP;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          m_ready = 1'b1;
    logic [FW-1:0] m_data;
    logic          m_valid;
    logic          err_frame;
    logic          err_overflow;

    int tests_run = 0;
    int tests_failed = 0;

    uart_rx_packer #(
        .CLOCKS_PER_PULSE(CPP),
        .BITS_PER_WORD(W),
        .N_WORDS(N),
        .TIMEOUT_PULSES(TOP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rx(rx),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .err_frame(err_frame),
        .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    // Character-level model state
    logic [W-1:0]  mdl_partial[$];
    logic [FW-1:0] exp_q[$];
    bit            mdl_held = 1'b0;
    bit            mdl_ovf = 1'b0;
    int            mdl_err = 0;

    // Monitor state
    int            frames_seen = 0;
    int            err_seen = 0;
    bit            mon_new = 1'b1;
    logic [FW-1:0] held_data = '0;
    logic [FW-1:0] last_frame = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        mdl_partial.delete();
        exp_q.delete();
        mdl_held = 1'b0;
        mdl_ovf  = 1'b0;
    endtask

    task automatic model_char(input logic [W-1:0] v, input bit good);
        logic [FW-1:0] f;
        if (!good) begin
            mdl_err++;
        end else begin
            mdl_partial.push_back(v);
            if (mdl_partial.size() == N) begin
                f = '0;
                for (int i = 0; i < N; i++) f[i*W +: W] = mdl_partial[i];
                mdl_partial.delete();
                if (mdl_held && !m_ready) begin
                    mdl_ovf = 1'b1;
                end else begin
                    exp_q.push_back(f);
                    mdl_held = 1'b1;
                end
            end
        end
    endtask

    task automatic model_gap(input int g);
        if (TOP > 0 && mdl_partial.size() > 0 && g > TO_CLKS) mdl_partial.delete();
    endtask

    task automatic send_char(input logic [W-1:0] v, input bit stop_ok, input bit par_ok, input int gap);
        rx = 1'b0;
        tick(CPP);
        for (int i = 0; i < W; i++) begin
            rx = v[i];
            tick(CPP);
        end
`ifdef UART_RX_PARITY_EN
        rx = par_ok ? (^v) : ~(^v);
        tick(CPP);
        model_char(v, stop_ok && par_ok);
`else
        model_char(v, stop_ok && par_ok);
`endif
        rx = stop_ok;
        tick(CPP);
        rx = 1'b1;
        model_gap(gap);
        tick(gap);
    endtask

    always @(posedge clk) begin
        if (m_ready) mdl_held = 1'b0;
    end

    // Compare process: each new frame must match the model, held frames must stay stable
    always @(negedge clk) begin
        if (rst) begin
            mon_new = 1'b1;
        end else begin
            if (err_frame) err_seen++;
            if (m_valid) begin
                if (mon_new) begin
                    frames_seen++;
                    if (exp_q.size() == 0) check("unexpected_frame", m_data, 64'h0);
                    else check("frame_vs_model", m_data, exp_q.pop_front());
                    held_data  = m_data;
                    last_frame = m_data;
                    mon_new    = 1'b0;
                end else begin
                    check("held_stable", m_data, held_data);
                end
                if (m_ready) mon_new = 1'b1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fs0;
        int es0;
        rst = 1'b1; rx = 1'b1; m_ready = 1'b1;
        tick(4);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_data", m_data, 32'h0);
        check("rst_err_frame", err_frame, 1'b0);
        check("rst_err_overflow", err_overflow, 1'b0);
        rst = 1'b0;
        tick(4);

        // Basic frame with random gaps
        fs0 = frames_seen;
        for (int i = 0; i < 4; i++) send_char(8'(8'h0A + i), 1'b1, 1'b1, int'($urandom_range(20, 1)));
        tick(20);
        check("t030_frames", frames_seen - fs0, 1);
        check("t030_data", last_frame, 32'h0D0C0B0A);
        check("t030_valid_low", m_valid, 1'b0);
        check("t030_queue", exp_q.size(), 0);
        check("t030_ovf", err_overflow, 1'b0);

        // Overflow while consumer stalls
        m_ready = 1'b0;
        fs0 = frames_seen;
        for (int i = 0; i < 4; i++) send_char(8'(8'h01 + i), 1'b1, 1'b1, 5);
        for (int i = 0; i < 4; i++) send_char(8'(8'h05 + i), 1'b1, 1'b1, 10);
        check("t031_valid", m_valid, 1'b1);
        check("t031_data", m_data, 32'h04030201);
        check("t031_ovf", err_overflow, 1'b1);
        check("t031_ovf_model", err_overflow, mdl_ovf);
        check("t031_frames", frames_seen - fs0, 1);
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (!m_valid) break;
        end
        check("t031_valid_fall", m_valid, 1'b0);
        tick(5);

        // Stop-bit error, then a good frame
        fs0 = frames_seen;
        es0 = err_seen;
        send_char(8'h55, 1'b0, 1'b1, 8);
        for (int i = 0; i < 4; i++) send_char(8'(8'h11 * (i + 1)), 1'b1, 1'b1, 3);
        tick(20);
        check("t032_err_pulses", err_seen - es0, 1);
        check("t032_err_model", err_seen, mdl_err);
        check("t032_data", last_frame, 32'h44332211);
        check("t032_frames", frames_seen - fs0, 1);
        check("t032_ovf_sticky", err_overflow, 1'b1);

        // Timeout discards a partial frame
        fs0 = frames_seen;
        send_char(8'h5A, 1'b1, 1'b1, 3);
        send_char(8'h5B, 1'b1, 1'b1, 40 * CPP);
        for (int i = 0; i < 4; i++) send_char(8'(8'hA1 + i), 1'b1, 1'b1, 3);
        tick(20);
        check("t033_data", last_frame, 32'hA4A3A2A1);
        check("t033_frames", frames_seen - fs0, 1);
        check("t033_queue", exp_q.size(), 0);

        // One-clock glitch in IDLE, then a clean frame
        fs0 = frames_seen;
        es0 = err_seen;
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(20);
        check("t034_glitch_err", err_seen - es0, 0);
        for (int i = 0; i < 4; i++) send_char(8'(8'h01 + i), 1'b1, 1'b1, 3);
        tick(20);
        check("t034_glitch_data", last_frame, 32'h04030201);
        check("t034_glitch_frames", frames_seen - fs0, 1);

        // Reset mid-frame and mid-byte
        send_char(8'h99, 1'b1, 1'b1, 5);
        rx = 1'b0;
        tick(CPP);
        rx = 1'b1;
        tick(2 * CPP);
        rst = 1'b1;
        model_reset();
        tick(3);
        check("t034_rst_valid", m_valid, 1'b0);
        check("t034_rst_data", m_data, 32'h0);
        check("t034_rst_ovf", err_overflow, 1'b0);
        rst = 1'b0;
        tick(8);
        fs0 = frames_seen;
        send_char(8'hEF, 1'b1, 1'b1, 4);
        send_char(8'hBE, 1'b1, 1'b1, 4);
        send_char(8'hAD, 1'b1, 1'b1, 4);
        send_char(8'hDE, 1'b1, 1'b1, 4);
        tick(20);
        check("t034_deadbeef", last_frame, 32'hDEADBEEF);
        check("t034_frames", frames_seen - fs0, 1);
        check("t034_ovf_clear", err_overflow, 1'b0);

`ifdef UART_RX_PARITY_EN
        fs0 = frames_seen;
        es0 = err_seen;
        send_char(8'h07, 1'b1, 1'b0, 6);
        send_char(8'h07, 1'b1, 1'b1, 4);
        send_char(8'h01, 1'b1, 1'b1, 4);
        send_char(8'h02, 1'b1, 1'b1, 4);
        send_char(8'h03, 1'b1, 1'b1, 4);
        tick(20);
        check("t035_par_err", err_seen - es0, 1);
        check("t035_data", last_frame, 32'h03020107);
        check("t035_frames", frames_seen - fs0, 1);
`endif

        check("final_err_model", err_seen, mdl_err);
        check("final_queue", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
